// File: rtl/glitch_filter.sv
// Single-bit input conditioner: two-flop synchroniser followed by a debounce FSM that
// accepts a new level only after it has held for STABLE_CYCLES samples and counts rejected excursions.
module glitch_filter #(
  parameter int       STABLE_CYCLES = 4,
  parameter logic     RESET_VAL     = 1'b0,
  parameter int       CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             clear_cnt,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_count
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [RUN_W-1:0] RUN_ZERO = '0;
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  generate
    if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("glitch_filter: STABLE_CYCLES must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("glitch_filter: CNT_W must be at least 1");
    end
  endgenerate

  // Synchroniser and registered state.
  logic             r_s1;
  logic             r_s2;
  logic [0:0]       r_state;
  logic [RUN_W-1:0] r_run;
  logic             r_dout;
  logic             r_rise;
  logic             r_fall;
  logic             r_glitch;
  logic [CNT_W-1:0] r_count;

  // Next-state values.
  logic             w_ds;
  logic             w_differs;
  logic             w_accept;
  logic             w_reject;
  logic [0:0]       w_state_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_dout_nxt;
  logic [CNT_W-1:0] w_count_base;
  logic [CNT_W-1:0] w_count_nxt;

  // The FSM only ever looks at the second synchroniser stage, never at din.
  assign w_ds      = r_s2;
  assign w_differs = (w_ds != r_dout);
  assign w_accept  = (r_state == ST_PEND) && w_differs && (r_run == RUN_LAST);
  assign w_reject  = (r_state == ST_PEND) && !w_differs;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned,
    // which is what keeps synthesis from inferring latches.
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_dout_nxt  = r_dout;

    case (r_state)
      ST_IDLE: begin
        if (w_differs) begin
          w_state_nxt = ST_PEND;
          w_run_nxt   = RUN_ONE;
        end else begin
          w_run_nxt   = RUN_ZERO;
        end
      end
      ST_PEND: begin
        if (!w_differs) begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = RUN_ZERO;
        end else if (w_accept) begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = RUN_ZERO;
          w_dout_nxt  = w_ds;
        end else begin
          w_run_nxt   = r_run + RUN_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_run_nxt   = RUN_ZERO;
      end
    endcase
  end

  // Clear takes effect first, so a rejection in the same cycle leaves the count at one.
  always_comb begin
    w_count_base = clear_cnt ? CNT_ZERO : r_count;
    w_count_nxt  = w_count_base;
    if (w_reject && (w_count_base != CNT_MAX)) begin
      w_count_nxt = w_count_base + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of the others; blocking here would collapse the synchroniser to one stage.
    if (reset) begin
      r_s1     <= RESET_VAL;
      r_s2     <= RESET_VAL;
      r_state  <= ST_IDLE;
      r_run    <= RUN_ZERO;
      r_dout   <= RESET_VAL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= 1'b0;
      r_count  <= CNT_ZERO;
    end else begin
      r_s1     <= din;
      r_s2     <= r_s1;
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_dout   <= w_dout_nxt;
      r_rise   <= w_accept && w_ds;
      r_fall   <= w_accept && !w_ds;
      r_glitch <= w_reject;
      r_count  <= w_count_nxt;
    end
  end

  assign dout         = r_dout;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign glitch       = r_glitch;
  assign glitch_count = r_count;

endmodule
